// File: rtl/video_timing_pkg.sv
// Shared raster timing defaults (720p), bridge state encoding and
// line/frame length helpers for the video output path.
package video_timing_pkg;

   localparam int DEF_DATA_W   = 24;
   localparam int DEF_H_ACTIVE = 1280;
   localparam int DEF_H_FP     = 110;
   localparam int DEF_H_SYNC   = 40;
   localparam int DEF_H_BP     = 220;
   localparam int DEF_V_ACTIVE = 720;
   localparam int DEF_V_FP     = 5;
   localparam int DEF_V_SYNC   = 5;
   localparam int DEF_V_BP     = 20;

   typedef enum logic [1:0] {
      WAIT_SOF = 2'd0,
      RUN      = 2'd1,
      FLUSH    = 2'd2
   } state_e;

   function automatic int h_tot(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   function automatic int v_tot(input int act, input int fp, input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO: rdata_o shows the head entry
// whenever empty_o is low. Push when full and pop when empty are ignored.
module sync_fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/axis_to_video_out.sv
// AXI-Stream pixel stream to raster video (vsync/hsync/den + RGB). Buffers
// pixels in a FWFT FIFO and re-locks to tuser after underflow or misalignment.
module axis_to_video_out
   import video_timing_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int H_FP       = DEF_H_FP,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BP       = DEF_H_BP,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int V_FP       = DEF_V_FP,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BP       = DEF_V_BP,
   parameter int FIFO_DEPTH = 64,
   parameter int PREFILL    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic              s_axis_tuser,
   input  logic              s_axis_tlast,
   output logic              out_vsync,
   output logic              out_hsync,
   output logic              out_den,
   output logic [DATA_W-1:0] out_data,
   output logic              underflow,
   output logic              sof_error,
   output state_e            state_o
);

   localparam int H_TOT = h_tot(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOT = v_tot(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HW    = $clog2(H_TOT);
   localparam int VW    = $clog2(V_TOT);
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int EW    = DATA_W + 2;

   localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_LAST_L = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0] H_SS_L   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE_L   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_END_L  = HW'(H_TOT - 1);
   localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS_L   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE_L   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_END_L  = VW'(V_TOT - 1);

   logic [EW-1:0]     fifo_rdata;
   logic              fifo_empty;
   logic              fifo_full;
   logic [CW-1:0]     fifo_count;
   logic              push;
   logic              pop;
   logic              head_user;
   logic              head_last;
   logic [DATA_W-1:0] head_data;

   state_e            state_q;
   logic [HW-1:0]     h_q, h_d;
   logic [VW-1:0]     v_q, v_d;
   logic              vsync_q, hsync_q, den_q, underflow_q, sof_error_q;
   logic [DATA_W-1:0] data_q;
   logic              pix_active, frame_wrap, tuser_bad, tlast_bad, start_ok;

   // A beat transfers on a clock where tvalid && tready are both high;
   // tready depends only on FIFO occupancy, never on tvalid.
   assign s_axis_tready = ~fifo_full;
   assign push          = s_axis_tvalid & s_axis_tready;
   assign head_user     = fifo_rdata[EW-1];
   assign head_last     = fifo_rdata[EW-2];
   assign head_data     = fifo_rdata[DATA_W-1:0];

   sync_fifo_fwft #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i ({s_axis_tuser, s_axis_tlast, s_axis_tdata}),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .count_o (fifo_count)
   );

   always_comb begin
      pix_active = (h_q < H_ACT_L) && (v_q < V_ACT_L);
      frame_wrap = (h_q == H_END_L) && (v_q == V_END_L);
      tuser_bad  = head_user != ((h_q == '0) && (v_q == '0));
      tlast_bad  = head_last != (h_q == H_LAST_L);
      start_ok   = ~fifo_empty && head_user && (fifo_count >= CW'(PREFILL));
      h_d        = (h_q == H_END_L) ? '0 : h_q + HW'(1);
      v_d        = v_q;
      if (h_q == H_END_L) v_d = (v_q == V_END_L) ? '0 : v_q + VW'(1);
      pop = 1'b0;
      case (state_q)
         WAIT_SOF, FLUSH: pop = ~fifo_empty & ~head_user;
         RUN:             pop = pix_active & ~fifo_empty & ~tuser_bad & ~tlast_bad;
         default:         pop = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= WAIT_SOF;
         h_q         <= '0;
         v_q         <= '0;
         vsync_q     <= 1'b0;
         hsync_q     <= 1'b0;
         den_q       <= 1'b0;
         data_q      <= '0;
         underflow_q <= 1'b0;
         sof_error_q <= 1'b0;
      end else begin
         underflow_q <= 1'b0;
         sof_error_q <= 1'b0;
         case (state_q)
            WAIT_SOF: begin
               h_q     <= '0;
               v_q     <= '0;
               vsync_q <= 1'b0;
               hsync_q <= 1'b0;
               den_q   <= 1'b0;
               data_q  <= '0;
               if (start_ok) state_q <= RUN;
            end
            RUN, FLUSH: begin
               h_q     <= h_d;
               v_q     <= v_d;
               hsync_q <= (h_q >= H_SS_L) && (h_q < H_SE_L);
               vsync_q <= (v_q >= V_SS_L) && (v_q < V_SE_L);
               den_q   <= pix_active;
               data_q  <= '0;
               // A bad pixel is blanked; FLUSH keeps timing until the frame ends.
               if (state_q == RUN && pix_active) begin
                  if (fifo_empty) begin
                     underflow_q <= 1'b1;
                     state_q     <= FLUSH;
                  end else if (tuser_bad || tlast_bad) begin
                     sof_error_q <= 1'b1;
                     state_q     <= FLUSH;
                  end else begin
                     data_q <= head_data;
                  end
               end else if (state_q == FLUSH && frame_wrap) begin
                  state_q <= WAIT_SOF;
               end
            end
            default: state_q <= WAIT_SOF;
         endcase
      end
   end

   assign out_vsync = vsync_q;
   assign out_hsync = hsync_q;
   assign out_den   = den_q;
   assign out_data  = data_q;
   assign underflow = underflow_q;
   assign sof_error = sof_error_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_axis_to_video_out.sv
// Directed bench for axis_to_video_out with a tiny 8x6 raster (4x3 active).
module tb_axis_to_video_out;
   import video_timing_pkg::*;

   localparam int DW = 24;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] s_axis_tdata = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic          s_axis_tuser = 1'b0;
   logic          s_axis_tlast = 1'b0;
   logic          out_vsync, out_hsync, out_den, underflow, sof_error;
   logic [DW-1:0] out_data;
   state_e        dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] px_data [64];
   logic          px_user [64];
   logic          px_last [64];
   int            first_stall;
   int            n_stall;

   logic [DW-1:0] c_data [512];
   logic          c_den [512];
   logic          c_hs  [512];
   logic          c_vs  [512];
   logic          c_uf  [512];
   logic          c_se  [512];

   logic [DW-1:0] exp_q [$];

   always #5 clk = ~clk;

   axis_to_video_out #(
      .DATA_W (DW), .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
      .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .FIFO_DEPTH (8), .PREFILL (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tlast  (s_axis_tlast),
      .out_vsync     (out_vsync),
      .out_hsync     (out_hsync),
      .out_den       (out_den),
      .out_data      (out_data),
      .underflow     (underflow),
      .sof_error     (sof_error),
      .state_o       (dbg_state)
   );

   // ---------------- clock/reset and driver tasks ----------------
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      s_axis_tvalid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic set_pix(input int idx, input logic [DW-1:0] d, input logic u, input logic l);
      px_data[idx] = d;
      px_user[idx] = u;
      px_last[idx] = l;
   endtask

   // Presents beats at negedges; tready is stable there, so the beat
   // transfers at the following posedge exactly when tready was seen high.
   task automatic drive(input int n);
      int i;
      int it;
      i = 0;
      it = 0;
      first_stall = -1;
      n_stall = 0;
      while (i < n && it < 1000) begin
         @(negedge clk);
         s_axis_tdata  = px_data[i];
         s_axis_tuser  = px_user[i];
         s_axis_tlast  = px_last[i];
         s_axis_tvalid = 1'b1;
         if (s_axis_tready) i++;
         else begin
            n_stall++;
            if (first_stall < 0) first_stall = it;
         end
         it++;
      end
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      n_cmp++;
      if (i !== n) begin
         n_err++;
         $display("FAIL drive_budget accepted=%0d required=%0d", i, n);
      end
   endtask

   task automatic capture(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         c_data[k] = out_data;
         c_den[k]  = out_den;
         c_hs[k]   = out_hsync;
         c_vs[k]   = out_vsync;
         c_uf[k]   = underflow;
         c_se[k]   = sof_error;
      end
   endtask

   task automatic load_frame(input int base, input logic [DW-1:0] d0);
      for (int i = 0; i < 12; i++) set_pix(base + i, d0 + DW'(i), i == 0, (i % 4) == 3);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [DW+5:0] got;
      logic [DW+5:0] exp;
      int bad;
      do_reset();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         s_axis_tdata  = DW'(k + 1);
         s_axis_tuser  = (k == 0);
         s_axis_tlast  = (k % 4) == 3;
         s_axis_tvalid = 1'b1;
      end
      @(negedge clk);
      n_cmp++;
      if ({out_den, out_data} !== {1'b1, 24'h000003}) begin
         n_err++;
         $display("FAIL reset_prerun got=%b/%h exp=1/000003", out_den, out_data);
      end
      rst = 1'b1;
      s_axis_tdata = 24'h000009;
      s_axis_tuser = 1'b0;
      exp = {{(DW+5){1'b0}}, 1'b1};
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         got = {out_vsync, out_hsync, out_den, out_data, underflow, sof_error, s_axis_tready};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL reset_outputs cyc=%0d got=%h exp=%h", r, got, exp);
         end
         n_cmp++;
         if (dbg_state !== WAIT_SOF) begin
            n_err++;
            $display("FAIL reset_state cyc=%0d got=%0d exp=%0d", r, dbg_state, WAIT_SOF);
         end
      end
      rst = 1'b0;
      s_axis_tvalid = 1'b0;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_den || out_hsync || out_vsync || !s_axis_tready || out_data != '0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL reset_idle active_cycles=%0d exp=0", bad);
      end
   endtask

   task automatic test_nominal();
      int t0;
      int l;
      int k;
      int nuf;
      int nse;
      logic [DW+2:0] got;
      logic [DW+2:0] exp;
      do_reset();
      load_frame(0, 24'h000001);
      fork
         drive(12);
         capture(60);
      join
      t0 = -1;
      for (int s = 59; s >= 0; s--) if (c_den[s]) t0 = s;
      n_cmp++;
      if (t0 !== 6) begin
         n_err++;
         $display("FAIL nominal_first_den got=%0d exp=6", t0);
      end
      for (int s = 0; s < 48; s++) begin
         l = s / 8;
         k = s % 8;
         exp = {l == 4, (k == 5) || (k == 6), (l < 3) && (k < 4),
                ((l < 3) && (k < 4)) ? DW'(4 * l + k + 1) : DW'(0)};
         got = {c_vs[6 + s], c_hs[6 + s], c_den[6 + s], c_data[6 + s]};
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL nominal_raster s=%0d got=%h exp=%h", s, got, exp);
         end
      end
      n_cmp++;
      if ({c_uf[54], c_den[54], c_data[54]} !== {2'b11, 24'h0}) begin
         n_err++;
         $display("FAIL nominal_period uf/den/data=%b%b/%h exp=11/000000", c_uf[54], c_den[54], c_data[54]);
      end
      nuf = 0;
      nse = 0;
      for (int s = 0; s < 60; s++) begin
         if (c_uf[s]) nuf++;
         if (c_se[s]) nse++;
      end
      n_cmp++;
      if (nuf !== 1 || nse !== 0) begin
         n_err++;
         $display("FAIL nominal_pulses uf=%0d se=%0d exp=1/0", nuf, nse);
      end
   endtask

   task automatic test_backpressure();
      int extra;
      int npulse;
      logic [DW-1:0] e;
      do_reset();
      for (int i = 0; i < 24; i++) set_pix(i, 24'h000100 + DW'(i), (i % 12) == 0, (i % 4) == 3);
      fork
         drive(24);
         capture(110);
      join
      n_cmp++;
      if (first_stall !== 12) begin
         n_err++;
         $display("FAIL bp_first_stall got=%0d exp=12", first_stall);
      end
      exp_q.delete();
      for (int j = 0; j < 24; j++) exp_q.push_back(24'h000100 + DW'(j));
      extra = 0;
      npulse = 0;
      for (int s = 0; s < 102; s++) begin
         if (c_uf[s] || c_se[s]) npulse++;
         if (c_den[s]) begin
            if (exp_q.size() == 0) extra++;
            else begin
               e = exp_q.pop_front();
               n_cmp++;
               if (c_data[s] !== e) begin
                  n_err++;
                  $display("FAIL bp_pixel s=%0d got=%h exp=%h", s, c_data[s], e);
               end
            end
         end
      end
      n_cmp++;
      if (exp_q.size() !== 0 || extra !== 0 || npulse !== 0) begin
         n_err++;
         $display("FAIL bp_count missing=%0d extra=%0d pulses=%0d exp=0/0/0", exp_q.size(), extra, npulse);
      end
      n_cmp++;
      if (c_uf[102] !== 1'b1) begin
         n_err++;
         $display("FAIL bp_third_frame_underflow got=%b exp=1", c_uf[102]);
      end
   endtask

   task automatic test_garbage();
      int t0;
      int nden;
      logic [DW-1:0] e;
      do_reset();
      for (int i = 0; i < 3; i++) set_pix(i, 24'hBAD000 + DW'(i), 1'b0, 1'b0);
      load_frame(3, 24'h000301);
      fork
         drive(15);
         capture(60);
      join
      t0 = -1;
      for (int s = 59; s >= 0; s--) if (c_den[s]) t0 = s;
      n_cmp++;
      if (t0 !== 9) begin
         n_err++;
         $display("FAIL garbage_first_den got=%0d exp=9", t0);
      end
      exp_q.delete();
      for (int j = 0; j < 12; j++) exp_q.push_back(24'h000301 + DW'(j));
      nden = 0;
      for (int s = 0; s < 57; s++) begin
         if (c_den[s] && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            nden++;
            n_cmp++;
            if (c_data[s] !== e) begin
               n_err++;
               $display("FAIL garbage_pixel s=%0d got=%h exp=%h", s, c_data[s], e);
            end
         end
      end
      n_cmp++;
      if (nden !== 12) begin
         n_err++;
         $display("FAIL garbage_count got=%0d exp=12", nden);
      end
   endtask

   task automatic test_underflow();
      int nuf;
      int nden;
      int nz;
      int t0;
      logic [DW-1:0] e;
      do_reset();
      for (int i = 0; i < 6; i++) set_pix(i, 24'h000401 + DW'(i), i == 0, i == 3);
      fork
         drive(6);
         capture(60);
      join
      n_cmp++;
      if ({c_uf[16], c_den[16], c_data[16]} !== {2'b11, 24'h0}) begin
         n_err++;
         $display("FAIL uf_pulse uf/den/data=%b%b/%h exp=11/000000", c_uf[16], c_den[16], c_data[16]);
      end
      n_cmp++;
      if ({c_data[6], c_data[9], c_data[14], c_data[15]} !== {24'h000401, 24'h000404, 24'h000405, 24'h000406}) begin
         n_err++;
         $display("FAIL uf_pixels got=%h %h %h %h exp=000401 000404 000405 000406",
                  c_data[6], c_data[9], c_data[14], c_data[15]);
      end
      nuf = 0;
      nden = 0;
      nz = 0;
      for (int s = 0; s < 60; s++) begin
         if (c_uf[s]) nuf++;
         if (c_den[s]) nden++;
         if (s >= 16 && c_data[s] != '0) nz++;
      end
      n_cmp++;
      if (nuf !== 1 || nden !== 12 || nz !== 0) begin
         n_err++;
         $display("FAIL uf_flush uf=%0d den=%0d nonzero=%0d exp=1/12/0", nuf, nden, nz);
      end
      load_frame(0, 24'h000501);
      fork
         drive(12);
         capture(60);
      join
      t0 = -1;
      for (int s = 59; s >= 0; s--) if (c_den[s]) t0 = s;
      n_cmp++;
      if (t0 !== 6) begin
         n_err++;
         $display("FAIL uf_relock_first_den got=%0d exp=6", t0);
      end
      exp_q.delete();
      for (int j = 0; j < 12; j++) exp_q.push_back(24'h000501 + DW'(j));
      for (int s = 0; s < 54; s++) begin
         if (c_den[s] && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (c_data[s] !== e) begin
               n_err++;
               $display("FAIL uf_relock_pixel s=%0d got=%h exp=%h", s, c_data[s], e);
            end
         end
      end
      n_cmp++;
      if (exp_q.size() !== 0) begin
         n_err++;
         $display("FAIL uf_relock_count missing=%0d exp=0", exp_q.size());
      end
   endtask

   task automatic test_misalign();
      int nse;
      int nuf;
      int nz;
      int nden;
      logic [DW-1:0] e;
      do_reset();
      for (int i = 0; i < 12; i++) set_pix(i, 24'h000601 + DW'(i), i == 0, (i == 2) || ((i % 4) == 3));
      load_frame(12, 24'h000701);
      fork
         drive(24);
         capture(110);
      join
      n_cmp++;
      if ({c_data[6], c_data[7]} !== {24'h000601, 24'h000602}) begin
         n_err++;
         $display("FAIL mis_head got=%h %h exp=000601 000602", c_data[6], c_data[7]);
      end
      n_cmp++;
      if ({c_se[8], c_den[8], c_data[8]} !== {2'b11, 24'h0}) begin
         n_err++;
         $display("FAIL mis_pulse se/den/data=%b%b/%h exp=11/000000", c_se[8], c_den[8], c_data[8]);
      end
      nse = 0;
      nuf = 0;
      nz = 0;
      for (int s = 0; s < 103; s++) begin
         if (c_se[s]) nse++;
         if (c_uf[s]) nuf++;
         if (s >= 8 && s < 55 && c_data[s] != '0) nz++;
      end
      n_cmp++;
      if (nse !== 1 || nuf !== 0 || nz !== 0) begin
         n_err++;
         $display("FAIL mis_flush se=%0d uf=%0d nonzero=%0d exp=1/0/0", nse, nuf, nz);
      end
      n_cmp++;
      if ({c_den[54], c_den[55], c_data[55]} !== {2'b01, 24'h000701}) begin
         n_err++;
         $display("FAIL mis_relock_start den54/den55/data=%b%b/%h exp=01/000701", c_den[54], c_den[55], c_data[55]);
      end
      exp_q.delete();
      for (int j = 0; j < 12; j++) exp_q.push_back(24'h000701 + DW'(j));
      nden = 0;
      for (int s = 55; s < 103; s++) begin
         if (c_den[s]) begin
            nden++;
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               n_cmp++;
               if (c_data[s] !== e) begin
                  n_err++;
                  $display("FAIL mis_relock_pixel s=%0d got=%h exp=%h", s, c_data[s], e);
               end
            end
         end
      end
      n_cmp++;
      if (nden !== 12) begin
         n_err++;
         $display("FAIL mis_relock_count got=%0d exp=12", nden);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_nominal();
      test_backpressure();
      test_garbage();
      test_underflow();
      test_misalign();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
